// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared widths for the EX/MEM boundary register and its entry storage.
// The payload is a flat vector packed as
//   {alu_result, store_value, dest, wb_en, mem_read, mem_write}
// with the control bits in the three least-significant positions.
package ex_mem_skid_reg_pkg;

    localparam int WORD_LEN          = 32;
    localparam int REG_ADDR_LEN      = 5;
    localparam int EXMEM_PAYLOAD_LEN = 2 * WORD_LEN + REG_ADDR_LEN + 3;

    // Payload width for an arbitrary word / register-index width.
    function automatic int payload_len(input int word_len, input int reg_addr_len);
        return 2 * word_len + reg_addr_len + 3;
    endfunction

endpackage

// File: rtl/ex_mem_skid_reg_entry.sv
// One storage slot of the EX/MEM register: a valid bit plus a payload.
// clear drops the valid bit but leaves the payload untouched, because every
// consumer qualifies the control bits with valid. The payload only updates
// when a valid entry is written, so an empty slot keeps its last contents.
module pipe_entry_reg
    import ex_mem_skid_reg_pkg::*;
#(
    parameter int WIDTH = EXMEM_PAYLOAD_LEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             d_valid,
    input  logic [WIDTH-1:0] d,
    output logic             valid,
    output logic [WIDTH-1:0] q
);

    // Valid bit: clear wins, otherwise a load writes the incoming valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= d_valid;
        end
    end

    // Payload: captured only together with a valid entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load && d_valid && !clear) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline boundary register with a one-entry skid buffer.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high on that side; valid must not depend on ready, and in_ready here
// is a flop so it never depends combinationally on out_ready.
//
// The main entry drives the outputs; the skid entry catches the one
// instruction that arrives while main is stalled. Skid contents always move
// to main before any newer input is taken, which keeps ordering strict FIFO.
module ex_mem_skid_reg #(
    parameter int WORD_LEN     = ex_mem_skid_reg_pkg::WORD_LEN,
    parameter int REG_ADDR_LEN = ex_mem_skid_reg_pkg::REG_ADDR_LEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORD_LEN-1:0]     in_alu_result,
    input  logic [WORD_LEN-1:0]     in_store_value,
    input  logic [REG_ADDR_LEN-1:0] in_dest,
    input  logic                    in_wb_en,
    input  logic                    in_mem_read,
    input  logic                    in_mem_write,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WORD_LEN-1:0]     ALU_Result,
    output logic [WORD_LEN-1:0]     Store_Value,
    output logic [REG_ADDR_LEN-1:0] Dest,
    output logic                    WB_EN,
    output logic                    Mem_Read_EN,
    output logic                    Mem_Write_EN
);

    import ex_mem_skid_reg_pkg::*;

    localparam int PAYLOAD_LEN = payload_len(WORD_LEN, REG_ADDR_LEN);

    logic [PAYLOAD_LEN-1:0] in_payload;
    logic [PAYLOAD_LEN-1:0] main_q;
    logic [PAYLOAD_LEN-1:0] skid_q;
    logic [PAYLOAD_LEN-1:0] main_d;
    logic [PAYLOAD_LEN-1:0] skid_d;
    logic                   main_valid;
    logic                   skid_valid;
    logic                   main_load;
    logic                   main_d_valid;
    logic                   skid_load;
    logic                   skid_d_valid;
    logic                   skid_valid_next;
    logic                   accept;
    logic                   drain;
    logic                   main_free;
    logic                   main_wb;
    logic                   main_rd;
    logic                   main_wr;

    assign in_payload = {in_alu_result, in_store_value, in_dest,
                         in_wb_en, in_mem_read, in_mem_write};

    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;
    // Main can take something this edge if it is empty or being consumed.
    assign main_free = !main_valid || drain;

    // Steering: decide what each entry loads on this edge.
    always_comb begin
        main_load       = 1'b0;
        main_d_valid    = 1'b0;
        main_d          = in_payload;
        skid_load       = 1'b0;
        skid_d_valid    = 1'b0;
        skid_d          = in_payload;
        skid_valid_next = skid_valid;
        if (flush) begin
            skid_valid_next = 1'b0;
        end else if (main_free) begin
            main_load = 1'b1;
            if (skid_valid) begin
                // Older skid instruction goes first; in_ready is low so
                // nothing new is accepted on this edge.
                main_d_valid    = 1'b1;
                main_d          = skid_q;
                skid_load       = 1'b1;
                skid_d_valid    = 1'b0;
                skid_valid_next = 1'b0;
            end else begin
                main_d_valid = accept;
                main_d       = in_payload;
            end
        end else if (accept) begin
            // Main is stalled: park the new instruction in skid.
            skid_load       = 1'b1;
            skid_d_valid    = 1'b1;
            skid_valid_next = 1'b1;
        end
    end

    pipe_entry_reg #(
        .WIDTH(PAYLOAD_LEN)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (main_load),
        .d_valid(main_d_valid),
        .d      (main_d),
        .valid  (main_valid),
        .q      (main_q)
    );

    pipe_entry_reg #(
        .WIDTH(PAYLOAD_LEN)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .clear  (flush),
        .load   (skid_load),
        .d_valid(skid_d_valid),
        .d      (skid_d),
        .valid  (skid_valid),
        .q      (skid_q)
    );

    // Registered ready: mirrors an empty skid entry one edge ahead.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= !skid_valid_next;
        end
    end

    assign {ALU_Result, Store_Value, Dest, main_wb, main_rd, main_wr} = main_q;

    // Control bits are qualified so a bubble never writes anything.
    assign WB_EN        = main_wb && main_valid;
    assign Mem_Read_EN  = main_rd && main_valid;
    assign Mem_Write_EN = main_wr && main_valid;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed steps followed by a random run, all
// checked against a queue model of the instructions currently held.
module tb_ex_mem_skid_reg;

    localparam int WL = 32;
    localparam int RL = 5;
    localparam int PW = 2 * WL + RL + 3;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [WL-1:0] in_alu_result;
    logic [WL-1:0] in_store_value;
    logic [RL-1:0] in_dest;
    logic          in_wb_en;
    logic          in_mem_read;
    logic          in_mem_write;
    logic          out_valid;
    logic          out_ready;
    logic [WL-1:0] ALU_Result;
    logic [WL-1:0] Store_Value;
    logic [RL-1:0] Dest;
    logic          WB_EN;
    logic          Mem_Read_EN;
    logic          Mem_Write_EN;

    logic [PW-1:0] exp_q[$];
    int total;
    int bad;

    ex_mem_skid_reg #(
        .WORD_LEN    (WL),
        .REG_ADDR_LEN(RL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_alu_result (in_alu_result),
        .in_store_value(in_store_value),
        .in_dest       (in_dest),
        .in_wb_en      (in_wb_en),
        .in_mem_read   (in_mem_read),
        .in_mem_write  (in_mem_write),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .ALU_Result    (ALU_Result),
        .Store_Value   (Store_Value),
        .Dest          (Dest),
        .WB_EN         (WB_EN),
        .Mem_Read_EN   (Mem_Read_EN),
        .Mem_Write_EN  (Mem_Write_EN)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PW-1:0] mk(input logic [WL-1:0] a, input logic [WL-1:0] s,
                                         input logic [RL-1:0] d, input logic wb,
                                         input logic rd, input logic wr);
        return {a, s, d, wb, rd, wr};
    endfunction

    function automatic logic [PW-1:0] rnd_payload();
        logic [WL-1:0] a;
        logic [WL-1:0] s;
        logic [RL-1:0] d;
        a = $urandom;
        s = $urandom;
        d = RL'($urandom_range(0, 31));
        return mk(a, s, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
    endfunction

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: the head of exp_q is what the MEM stage must see.
    task automatic check_model();
        logic [WL-1:0] a;
        logic [WL-1:0] s;
        logic [RL-1:0] d;
        logic          wb;
        logic          rd;
        logic          wr;
        logic          v;
        v = (exp_q.size() > 0);
        chk("out_valid", out_valid, v);
        chk("in_ready", in_ready, exp_q.size() < 2);
        if (v) begin
            {a, s, d, wb, rd, wr} = exp_q[0];
            chk("alu_result", ALU_Result, a);
            chk("store_value", Store_Value, s);
            chk("dest", Dest, d);
            chk("wb_en", WB_EN, wb);
            chk("mem_read", Mem_Read_EN, rd);
            chk("mem_write", Mem_Write_EN, wr);
        end else begin
            chk("bubble_ctrl", {WB_EN, Mem_Read_EN, Mem_Write_EN}, 3'b000);
        end
    endtask

    task automatic drive(input logic iv, input logic [PW-1:0] p, input logic ordy,
                         input logic fl);
        in_valid  = iv;
        {in_alu_result, in_store_value, in_dest, in_wb_en, in_mem_read, in_mem_write} = p;
        out_ready = ordy;
        flush     = fl;
    endtask

    // Driver: one clock with the given inputs, model update, then checks.
    task automatic step(input logic iv, input logic [PW-1:0] p, input logic ordy,
                        input logic fl);
        logic acc;
        logic drn;
        drive(iv, p, ordy, fl);
        acc = iv && (exp_q.size() < 2);
        drn = ordy && (exp_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(p);
        end
        @(negedge clk);
        check_model();
    endtask

    initial begin
        logic [PW-1:0] idle;
        total = 0;
        bad   = 0;
        idle  = '0;

        // Reset held low with random inputs: everything stays zero.
        rst = 1'b0;
        drive(1'b0, idle, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), rnd_payload(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
            @(negedge clk);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_outputs", {ALU_Result, Store_Value, Dest}, '0);
            chk("rst_ctrl", {WB_EN, Mem_Read_EN, Mem_Write_EN}, 3'b000);
        end
        drive(1'b0, idle, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_valid", out_valid, 1'b0);
        @(negedge clk);
        step(1'b0, idle, 1'b1, 1'b0);
        chk("post_rst_wr", Mem_Write_EN, 1'b0);

        // Streaming: 8 back-to-back stores with out_ready held high.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, mk(32'h100 + 32'(4 * i), 32'(i), RL'(i), 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
            chk("stream_alu", ALU_Result, 32'h100 + 32'(4 * i));
            chk("stream_ready", in_ready, 1'b1);
            chk("stream_valid", out_valid, 1'b1);
        end
        step(1'b0, idle, 1'b1, 1'b0);
        chk("stream_drained", out_valid, 1'b0);

        // Stall / skid: A held, B parked, C refused until space frees.
        step(1'b1, mk(32'hA, 32'h1, 5'd1, 1'b1, 1'b0, 1'b0), 1'b0, 1'b0);
        chk("stall_a", ALU_Result, 32'hA);
        step(1'b1, mk(32'hB, 32'h2, 5'd2, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
        chk("stall_hold_a", ALU_Result, 32'hA);
        chk("stall_ready_low", in_ready, 1'b0);
        step(1'b1, mk(32'hC, 32'h3, 5'd3, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
        chk("stall_c_refused", ALU_Result, 32'hA);
        step(1'b1, mk(32'hC, 32'h3, 5'd3, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        chk("order_b", ALU_Result, 32'hB);
        step(1'b1, mk(32'hC, 32'h3, 5'd3, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        chk("order_c", ALU_Result, 32'hC);
        step(1'b0, idle, 1'b1, 1'b0);
        chk("no_dup", out_valid, 1'b0);

        // Flush with both entries full and D offered in the same cycle.
        step(1'b1, mk(32'hE, 32'h4, 5'd4, 1'b1, 1'b0, 1'b1), 1'b0, 1'b0);
        step(1'b1, mk(32'hF, 32'h5, 5'd5, 1'b1, 1'b1, 1'b0), 1'b0, 1'b0);
        step(1'b1, mk(32'hD, 32'h6, 5'd6, 1'b1, 1'b1, 1'b1), 1'b0, 1'b1);
        chk("flush_valid", out_valid, 1'b0);
        chk("flush_ctrl", {WB_EN, Mem_Read_EN, Mem_Write_EN}, 3'b000);
        chk("flush_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, idle, 1'b1, 1'b0);
            chk("flush_no_d", out_valid, 1'b0);
        end

        // Asynchronous reset while a store is stalled in main.
        step(1'b1, mk(32'h40, 32'h77, 5'd7, 1'b0, 1'b0, 1'b1), 1'b0, 1'b0);
        step(1'b0, idle, 1'b0, 1'b0);
        chk("async_pre_wr", Mem_Write_EN, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_wr", Mem_Write_EN, 1'b0);
        chk("async_valid", out_valid, 1'b0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_ready", in_ready, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), rnd_payload(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0));
        end

        // Report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Pipeline boundary register between the execute stage and the memory stage of the 5-stage MIPS pipeline.
- Carries ALU result, store data, destination register and control bits into the memory stage.
- Uses a valid/ready handshake with a one-entry skid buffer, so a memory-stage stall never drops an in-flight instruction and in_ready stays registered (no combinational ready path).
- A synchronous flush squashes all contents on a branch or exception redirect.

Parameters:
- WORD_LEN, 32, width of data and address words
- REG_ADDR_LEN, 5, width of register-file index

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-low reset
- flush  input  1  synchronous squash of all held entries
- in_valid  input  1  EX stage presents an instruction
- in_ready  output  1  register can accept an instruction this cycle
- in_alu_result  input  WORD_LEN  ALU result / memory address
- in_store_value  input  WORD_LEN  store data
- in_dest  input  REG_ADDR_LEN  destination register
- in_wb_en  input  1  writeback enable
- in_mem_read  input  1  load
- in_mem_write  input  1  store
- out_valid  output  1  MEM stage has a valid instruction
- out_ready  input  1  MEM stage consumes the instruction this cycle
- ALU_Result  output  WORD_LEN  to memory-stage address
- Store_Value  output  WORD_LEN  to memory-stage write data
- Dest  output  REG_ADDR_LEN  destination register
- WB_EN  output  1  writeback enable, qualified by out_valid
- Mem_Read_EN  output  1  load enable, qualified by out_valid
- Mem_Write_EN  output  1  store enable, qualified by out_valid

Behaviour:
- Storage: a main entry (drives the outputs) and a skid entry, each holding a valid bit and the full payload.
- Reset (rst low, asynchronous): both valid bits are 0; all payload registers are 0; all outputs are 0; in_ready is 1 after reset is released.
- in_ready is a register equal to NOT skid_valid. It never depends combinationally on out_ready.
- Accept: the register takes an instruction when in_valid && in_ready. Drain: the MEM stage takes an instruction when out_valid && out_ready.
- Per rising edge, with flush = 0:
  - Main empty or draining, skid empty: an accepted input loads main. Latency is 1 cycle from accept to out_valid.
  - Main empty or draining, skid full: skid moves to main. in_ready is 0, so no input is accepted.
  - Main full and not draining, input accepted: the input goes to skid, and in_ready drops next cycle.
  - Main full and not draining, no input: hold.
- Ordering is strict FIFO. Skid content always reaches main before any newer instruction.
- Stalled outputs are stable. While out_valid && !out_ready, every output is held unchanged.
- Control qualification: WB_EN, Mem_Read_EN and Mem_Write_EN equal the stored bits ANDed with out_valid. A bubble can never write memory.
- Flush: on the edge where flush = 1, both valid bits are cleared and in_ready is set to 1. An input offered in the same cycle is discarded. Payload registers may keep stale data, but the control outputs are 0 because they are valid-qualified.
- Flush takes priority over accept and drain in the same cycle. A drain that completes in a flush cycle still counts as consumed by the MEM stage.
- Asserting rst mid-operation clears everything immediately, with no dependence on clk.
- Throughput: 1 instruction per cycle when out_ready is held at 1.

Decomposition:
- Shared package/defines file: WORD_LEN, REG_ADDR_LEN, and a packed payload struct or concatenation width constant (EXMEM_PAYLOAD_LEN = 2*WORD_LEN + REG_ADDR_LEN + 3).
- One natural sub-module, pipe_entry_reg: a payload register with a valid bit, load enable, clear, and asynchronous active-low reset. It is instantiated twice (main and skid).
- Handshake control stays in the top module.

Test Plan:
- Reset: hold rst=0 with random inputs, then release. Required: out_valid=0, all outputs 0, in_ready=1; Mem_Write_EN stays 0 until the first accept.
- Streaming: out_ready=1; send 8 back-to-back stores with ALU_Result 0x100..0x11C. Required: they appear 1 cycle later in order, out_valid is continuous, and in_ready stays 1.
- Stall/skid: out_ready=0; send A (0xA), then B (0xB). Required: A held on the outputs; B in skid; in_ready=0 the following cycle; a third offer C is not accepted. Raise out_ready. Required: A, B, C exit in order with no loss or duplication.
- Flush: with main and skid both full, assert flush while in_valid=1 with D. Required: next cycle out_valid=0, Mem_Write_EN=0, Mem_Read_EN=0, WB_EN=0, in_ready=1; D never appears.
- Async reset mid-stall: main holds a store to 0x40; pulse rst low between clock edges. Required: Mem_Write_EN falls immediately and out_valid=0.
- Random: random in_valid/out_ready/flush for 10k cycles against a scoreboard model. Required: FIFO order preserved, outputs stable under stall, no accept while in_ready=0.
